// File: rtl/perceptron_bp_pkg.sv
// rtl/perceptron_bp_pkg.sv - shared widths, saturating add, FSM states and threshold default for perceptron_bp
package perceptron_bp_pkg;

    localparam int THETA_DEFAULT = 29;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_TRAIN = 1'b1
    } state_e;

    // Wide enough for w0 plus HIST_LEN signed terms without overflow.
    function automatic int calc_sum_w(input int weight_w, input int hist_len);
        return weight_w + $clog2(hist_len + 1) + 1;
    endfunction

    function automatic int calc_idx_w(input int num_perc);
        return (num_perc > 1) ? $clog2(num_perc) : 1;
    endfunction

    // Symmetric clamp keeps -(2^(W-1)) unused so negation never wraps.
    function automatic int sat_add(input int value, input int delta, input int weight_w);
        int lim;
        int res;
        lim = (1 << (weight_w - 1)) - 1;
        res = value + delta;
        if (res > lim) begin
            res = lim;
        end else if (res < -lim) begin
            res = -lim;
        end
        return res;
    endfunction

endpackage

// File: rtl/perceptron_dot.sv
// rtl/perceptron_dot.sv - combinational perceptron dot product of one weight row against a history vector
module perceptron_dot
    import perceptron_bp_pkg::*;
#(
    parameter int  HIST_LEN = 8,
    parameter int  WEIGHT_W = 8,
    localparam int SUM_W    = calc_sum_w(WEIGHT_W, HIST_LEN)
) (
    input  logic [HIST_LEN:0][WEIGHT_W-1:0] i_row,
    input  logic [HIST_LEN-1:0]             i_hist,
    output logic signed [SUM_W-1:0]         o_sum
);

    logic signed [SUM_W-1:0] w_acc;

    always_comb begin
        w_acc = SUM_W'($signed(i_row[0]));
        for (int i = 0; i < HIST_LEN; i++) begin
            if (i_hist[i]) begin
                w_acc = w_acc + SUM_W'($signed(i_row[i+1]));
            end else begin
                w_acc = w_acc - SUM_W'($signed(i_row[i+1]));
            end
        end
    end

    assign o_sum = w_acc;

endmodule

// File: rtl/perceptron_bp.sv
// rtl/perceptron_bp.sv - perceptron branch predictor with speculative GHR and serial training FSM
// Optional: define PERCEPTRON_BP_PERF_EN to add prediction/mispredict counters.
module perceptron_bp
    import perceptron_bp_pkg::*;
#(
    parameter int  HIST_LEN = 8,
    parameter int  NUM_PERC = 16,
    parameter int  WEIGHT_W = 8,
    parameter int  PC_W     = 32,
    parameter int  THETA    = THETA_DEFAULT,
    localparam int SUM_W    = calc_sum_w(WEIGHT_W, HIST_LEN),
    localparam int IDX_W    = calc_idx_w(NUM_PERC)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pred_valid,
    output logic                    pred_ready,
    input  logic [PC_W-1:0]         pred_pc,
    output logic                    pred_out_valid,
    output logic                    pred_taken,
    output logic signed [SUM_W-1:0] pred_sum,
    output logic [HIST_LEN-1:0]     pred_hist,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [PC_W-1:0]         upd_pc,
    input  logic                    upd_taken,
    input  logic                    upd_pred_taken,
    input  logic signed [SUM_W-1:0] upd_sum,
    input  logic [HIST_LEN-1:0]     upd_hist
`ifdef PERCEPTRON_BP_PERF_EN
    ,
    output logic [31:0]             perf_pred_cnt,
    output logic [31:0]             perf_mispred_cnt
`endif
);

    localparam int CNT_W = $clog2(HIST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_J = CNT_W'(HIST_LEN);

    logic [HIST_LEN:0][WEIGHT_W-1:0] r_weights [NUM_PERC];
    state_e                  r_state;
    logic [HIST_LEN-1:0]     r_ghr;
    logic                    r_pred_out_valid;
    logic                    r_pred_taken;
    logic signed [SUM_W-1:0] r_pred_sum;
    logic [HIST_LEN-1:0]     r_pred_hist;
    logic [IDX_W-1:0]        r_trn_idx;
    logic                    r_trn_taken;
    logic [HIST_LEN-1:0]     r_trn_hist;
    logic [CNT_W-1:0]        r_trn_j;

    logic                            w_idle;
    logic                            w_pred_acc;
    logic                            w_upd_acc;
    logic                            w_mispred;
    logic                            w_low_conf;
    logic                            w_train_start;
    logic [IDX_W-1:0]                w_pred_idx;
    logic [IDX_W-1:0]                w_upd_idx;
    logic [HIST_LEN:0][WEIGHT_W-1:0] w_pred_row;
    logic signed [SUM_W-1:0]         w_pred_sum;
    logic                            w_pred_taken;
    logic [HIST_LEN:0]               w_hist_sh;
    logic signed [WEIGHT_W-1:0]      w_cur_w;
    logic signed [WEIGHT_W-1:0]      w_new_w;
    int                              w_delta;
    logic                            w_unused;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_pred_acc    = pred_valid & w_idle;
    assign w_upd_acc     = upd_valid & w_idle;
    assign w_mispred     = (upd_taken != upd_pred_taken);
    assign w_low_conf    = (int'(upd_sum) <= THETA) && (int'(upd_sum) >= -THETA);
    assign w_train_start = w_upd_acc & (w_mispred | w_low_conf);
    assign w_pred_idx    = pred_pc[IDX_W-1:0] ^ r_ghr[IDX_W-1:0];
    assign w_upd_idx     = upd_pc[IDX_W-1:0] ^ upd_hist[IDX_W-1:0];
    assign w_pred_row    = r_weights[w_pred_idx];
    assign w_pred_taken  = ~w_pred_sum[SUM_W-1];
    assign w_unused      = ^{pred_pc[PC_W-1:IDX_W], upd_pc[PC_W-1:IDX_W]};

    perceptron_dot #(
        .HIST_LEN (HIST_LEN),
        .WEIGHT_W (WEIGHT_W)
    ) u_dot (
        .i_row  (w_pred_row),
        .i_hist (r_ghr),
        .o_sum  (w_pred_sum)
    );

    // History shifted up by one so bit j lines up with weight j (bit 0 belongs to the bias).
    assign w_hist_sh = {r_trn_hist, 1'b0};

    always_comb begin
        w_cur_w = r_weights[r_trn_idx][r_trn_j];
        w_delta = 0;
        if (r_trn_j == '0) begin
            w_delta = r_trn_taken ? 1 : -1;
        end else begin
            w_delta = (r_trn_taken == w_hist_sh[r_trn_j]) ? 1 : -1;
        end
        w_new_w = WEIGHT_W'(sat_add(int'(w_cur_w), w_delta, WEIGHT_W));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PERC; p++) begin
                r_weights[p] <= '0;
            end
        end else if (r_state == ST_TRAIN) begin
            r_weights[r_trn_idx][r_trn_j] <= w_new_w;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_trn_idx   <= '0;
            r_trn_taken <= 1'b0;
            r_trn_hist  <= '0;
            r_trn_j     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_train_start) begin
                        r_state     <= ST_TRAIN;
                        r_trn_idx   <= w_upd_idx;
                        r_trn_taken <= upd_taken;
                        r_trn_hist  <= upd_hist;
                        r_trn_j     <= '0;
                    end
                end
                ST_TRAIN: begin
                    if (r_trn_j == LAST_J) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_trn_j <= r_trn_j + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A recovery restore wins over the speculative shift from a same-cycle prediction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ghr            <= '0;
            r_pred_out_valid <= 1'b0;
            r_pred_taken     <= 1'b0;
            r_pred_sum       <= '0;
            r_pred_hist      <= '0;
        end else begin
            r_pred_out_valid <= w_pred_acc;
            if (w_pred_acc) begin
                r_pred_taken <= w_pred_taken;
                r_pred_sum   <= w_pred_sum;
                r_pred_hist  <= r_ghr;
            end
            if (w_upd_acc && w_mispred) begin
                r_ghr <= {upd_hist[HIST_LEN-2:0], upd_taken};
            end else if (w_pred_acc) begin
                r_ghr <= {r_ghr[HIST_LEN-2:0], w_pred_taken};
            end
        end
    end

    assign pred_ready     = w_idle;
    assign upd_ready      = w_idle;
    assign pred_out_valid = r_pred_out_valid;
    assign pred_taken     = r_pred_taken;
    assign pred_sum       = r_pred_sum;
    assign pred_hist      = r_pred_hist;

`ifdef PERCEPTRON_BP_PERF_EN
    logic [31:0] r_perf_pred_cnt;
    logic [31:0] r_perf_mispred_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_pred_cnt    <= '0;
            r_perf_mispred_cnt <= '0;
        end else begin
            if (w_pred_acc) begin
                r_perf_pred_cnt <= r_perf_pred_cnt + 32'd1;
            end
            if (w_upd_acc && w_mispred) begin
                r_perf_mispred_cnt <= r_perf_mispred_cnt + 32'd1;
            end
        end
    end

    assign perf_pred_cnt    = r_perf_pred_cnt;
    assign perf_mispred_cnt = r_perf_mispred_cnt;
`endif

endmodule

// File: tb/tb_perceptron_bp.sv
// tb/tb_perceptron_bp.sv - directed self-checking bench for perceptron_bp with a per-cycle reference model
module tb_perceptron_bp;

    localparam int HL    = 8;
    localparam int NP    = 16;
    localparam int SW    = 13;
    localparam int THETA = 29;
    localparam int WMAX  = 127;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 pred_valid = 1'b0;
    logic                 pred_ready;
    logic [31:0]          pred_pc = '0;
    logic                 pred_out_valid;
    logic                 pred_taken;
    logic signed [SW-1:0] pred_sum;
    logic [HL-1:0]        pred_hist;
    logic                 upd_valid = 1'b0;
    logic                 upd_ready;
    logic [31:0]          upd_pc = '0;
    logic                 upd_taken = 1'b0;
    logic                 upd_pred_taken = 1'b0;
    logic signed [SW-1:0] upd_sum = '0;
    logic [HL-1:0]        upd_hist = '0;
`ifdef PERCEPTRON_BP_PERF_EN
    logic [31:0]          perf_pred_cnt;
    logic [31:0]          perf_mispred_cnt;
`endif

    perceptron_bp dut (
        .clk            (clk),
        .reset          (reset),
        .pred_valid     (pred_valid),
        .pred_ready     (pred_ready),
        .pred_pc        (pred_pc),
        .pred_out_valid (pred_out_valid),
        .pred_taken     (pred_taken),
        .pred_sum       (pred_sum),
        .pred_hist      (pred_hist),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_pred_taken (upd_pred_taken),
        .upd_sum        (upd_sum),
        .upd_hist       (upd_hist)
`ifdef PERCEPTRON_BP_PERF_EN
        ,
        .perf_pred_cnt    (perf_pred_cnt),
        .perf_mispred_cnt (perf_mispred_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: whole training applied at once; busy counts the stall cycles.
    int mw [NP][HL+1];
    int m_ghr   = 0;
    int m_busy  = 0;
    bit m_ready = 1'b1;
    bit m_e_valid = 1'b0;
    int m_e_sum = 0;
    int m_e_taken = 0;
    int m_e_hist = 0;
    int m_pcnt = 0;
    int m_mcnt = 0;

    function automatic int m_dot(input int p, input int h);
        int s;
        s = mw[p][0];
        for (int i = 0; i < HL; i++) begin
            if (((h >> i) & 1) != 0) s = s + mw[p][i+1];
            else                     s = s - mw[p][i+1];
        end
        return s;
    endfunction

    function automatic int clampw(input int v);
        if (v > WMAX) return WMAX;
        if (v < -WMAX) return -WMAX;
        return v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NP; p++)
                for (int j = 0; j <= HL; j++) mw[p][j] = 0;
            m_ghr = 0; m_busy = 0; m_ready = 1'b1; m_e_valid = 1'b0;
            m_pcnt = 0; m_mcnt = 0;
        end else begin : model_step
            bit pa, ua, mis;
            int pidx, uidx, us, t, d, hb;
            pa  = pred_valid && m_ready;
            ua  = upd_valid && m_ready;
            mis = ua && (upd_taken != upd_pred_taken);
            m_e_valid = pa;
            if (pa) begin
                pidx = int'(pred_pc & 32'hF) ^ (m_ghr & 15);
                m_e_sum   = m_dot(pidx, m_ghr);
                m_e_taken = (m_e_sum >= 0) ? 1 : 0;
                m_e_hist  = m_ghr;
                m_pcnt++;
            end
            if (m_busy > 0) m_busy--;
            if (ua) begin
                us   = int'(upd_sum);
                uidx = int'(upd_pc & 32'hF) ^ int'(upd_hist & 8'hF);
                if (mis || (us <= THETA && us >= -THETA)) begin
                    t = upd_taken ? 1 : -1;
                    for (int j = 0; j <= HL; j++) begin
                        if (j == 0) d = t;
                        else begin
                            hb = (int'(upd_hist) >> (j - 1)) & 1;
                            d = (hb == int'(upd_taken)) ? 1 : -1;
                        end
                        mw[uidx][j] = clampw(mw[uidx][j] + d);
                    end
                    m_busy = HL + 1;
                end
                if (mis) m_mcnt++;
            end
            if (mis)     m_ghr = ((int'(upd_hist) << 1) | int'(upd_taken)) & 255;
            else if (pa) m_ghr = ((m_ghr << 1) | m_e_taken) & 255;
            m_ready = (m_busy == 0);
        end
    end

    always @(negedge clk) begin
        check("pred_ready", int'(pred_ready), int'(m_ready));
        check("upd_ready", int'(upd_ready), int'(m_ready));
        check("out_valid", int'(pred_out_valid), int'(m_e_valid));
        if (m_e_valid) begin
            check("model_sum", int'(pred_sum), m_e_sum);
            check("model_taken", int'(pred_taken), m_e_taken);
            check("model_hist", int'(pred_hist), m_e_hist);
        end
`ifdef PERCEPTRON_BP_PERF_EN
        check("model_perf_pred", int'(perf_pred_cnt), m_pcnt);
        check("model_perf_mispred", int'(perf_mispred_cnt), m_mcnt);
`endif
    end

    task automatic wait_ready();
        int n = 0;
        while (!m_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got busy after %0d cycles expected ready", n);
        end
    endtask

    task automatic do_pred(input logic [31:0] pc, output int s, output int h, output int tk);
        wait_ready();
        pred_pc = pc;
        pred_valid = 1'b1;
        @(negedge clk);
        pred_valid = 1'b0;
        s  = int'(pred_sum);
        h  = int'(pred_hist);
        tk = int'(pred_taken);
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic tk, input logic ptk,
                          input int s, input logic [HL-1:0] h);
        wait_ready();
        upd_pc = pc; upd_taken = tk; upd_pred_taken = ptk;
        upd_sum = SW'(s); upd_hist = h;
        upd_valid = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin : stim
        int s, h, tk, n;
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(pred_out_valid), 0);
        check("rst_sum", int'(pred_sum), 0);
        check("rst_taken", int'(pred_taken), 0);
        check("rst_hist", int'(pred_hist), 0);
        reset = 1'b0;
        @(negedge clk);

        do_pred(32'h0, s, h, tk);
        check("first_sum", s, 0);
        check("first_taken", tk, 1);
        check("first_hist", h, 0);

        for (int i = 0; i < 7; i++) do_pred(32'h4, s, h, tk);
        for (int i = 0; i < 40; i++) begin
            do_pred(32'h4, s, h, tk);
            do_upd(32'h4, 1'b1, 1'b1, s, 8'hFF);
        end
        do_pred(32'h4, s, h, tk);
        check("conf_sum", s, 36);
        check("conf_hist", h, 8'hFF);

        do_upd(32'h0, 1'b1, 1'b0, 0, 8'h0F);
        n = 0;
        while (!upd_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, 9);
        do_pred(32'h0, s, h, tk);
        check("restore_hist", h, 8'h1F);
        check("restore_sum", s, 7);

        wait_ready();
        pred_pc = 32'h9; pred_valid = 1'b1;
        upd_pc = 32'h5; upd_taken = 1'b0; upd_pred_taken = 1'b1;
        upd_sum = SW'(5); upd_hist = 8'h33; upd_valid = 1'b1;
        @(negedge clk);
        pred_valid = 1'b0; upd_valid = 1'b0;
        check("simul_old_sum", int'(pred_sum), 0);
        do_pred(32'h0, s, h, tk);
        check("simul_hist", h, 8'h66);
        check("simul_new_sum", s, -1);
        check("simul_new_taken", tk, 0);

        for (int i = 0; i < 130; i++) do_upd(32'h0, 1'b1, 1'b0, 0, 8'h00);
        do_pred(32'h1, s, h, tk);
        check("sat_sum", s, 889);
        check("sat_hist", h, 1);

        do_upd(32'h0, 1'b0, 1'b1, 0, 8'h01);
        repeat (2) @(negedge clk);
        do_reset();
        check("post_rst_ready", int'(pred_ready), 1);
        do_pred(32'h0, s, h, tk);
        check("post_rst_sum0", s, 0);
        do_pred(32'h0, s, h, tk);
        check("post_rst_sum1", s, 0);
        check("post_rst_hist", h, 1);

`ifdef PERCEPTRON_BP_PERF_EN
        do_reset();
        for (int i = 0; i < 5; i++) do_pred(32'h3, s, h, tk);
        do_upd(32'h2, 1'b1, 1'b0, 0, 8'h00);
        do_upd(32'h7, 1'b0, 1'b1, 0, 8'h01);
        do_upd(32'h7, 1'b1, 1'b1, 100, 8'h01);
        wait_ready();
        check("perf_pred", int'(perf_pred_cnt), 5);
        check("perf_mispred", int'(perf_mispred_cnt), 2);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
